bios_flash_loader: RTL and testbench

// - Boot-time copy engine: streams the BIOS image (NEXTOR 128KB + FM-BIOS 16KB) byte by byte

---
 rtl/bios_flash_loader.sv | 201 ++++++++++++++++++++
 tb/tb_bios_flash_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bios_flash_loader.sv
// Boot-time copy engine: streams LENGTH bytes from SPI flash into SD-RAM through a small FIFO.
// Optional running checksum on SUM is built only when BIOS_LOADER_SUM_EN is defined.
module bios_flash_loader #(
  parameter logic [23:0] SRC_ADDR   = 24'h10_0000,
  parameter logic [23:0] DST_ADDR   = 24'h70_0000,
  parameter logic [23:0] LENGTH     = 24'h02_4000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  output logic        BUSY,
  output logic        DONE,
  output logic        FLASH_REQ,
  output logic [23:0] FLASH_ADDR,
  input  logic        FLASH_ACK,
  input  logic [7:0]  FLASH_RDATA,
  output logic        RAM_REQ,
  output logic [23:0] RAM_ADDR,
  output logic [7:0]  RAM_WDATA,
  input  logic        RAM_ACK,
  output logic [15:0] SUM,
  output logic [1:0]  dbg_state
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  if (LENGTH == 24'd0) begin : g_len_err
    $error("bios_flash_loader: LENGTH must be at least 1");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_err
    $error("bios_flash_loader: FIFO_DEPTH must be a power of two in 2..16");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // Both REQ/ACK sides: REQ holds ADDR/WDATA stable until ACK, drops the cycle
  // after ACK, and may be re-raised in that same cycle for the next byte;
  // ACK while REQ is low is ignored.
  state_e          state_q, state_d;
  logic            done_q, done_d;
  logic            flash_req_q, flash_req_d;
  logic [23:0]     flash_addr_q, flash_addr_d;
  logic [23:0]     rd_rem_q, rd_rem_d;
  logic            ram_req_q, ram_req_d;
  logic [23:0]     ram_addr_q, ram_addr_d;
  logic [7:0]      ram_wdata_q, ram_wdata_d;
  logic [23:0]     wr_rem_q, wr_rem_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            push, pop, empty_after_pop;
  logic [7:0]      head_byte;

`ifdef BIOS_LOADER_SUM_EN
  logic [15:0]     sum_q, sum_d;
`endif

  always_comb begin
    state_d      = state_q;
    done_d       = done_q;
    flash_req_d  = flash_req_q;
    flash_addr_d = flash_addr_q;
    rd_rem_d     = rd_rem_q;
    ram_req_d    = ram_req_q;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    wr_rem_d     = wr_rem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
`ifdef BIOS_LOADER_SUM_EN
    sum_d        = sum_q;
`endif

    push = flash_req_q && FLASH_ACK;
    pop  = ram_req_q && RAM_ACK;

    if (push) begin
      flash_req_d  = 1'b0;
      wr_ptr_d     = wr_ptr_q + PW'(1);
      flash_addr_d = flash_addr_q + 24'd1;
      rd_rem_d     = rd_rem_q - 24'd1;
    end
    if (pop) begin
      ram_req_d  = 1'b0;
      rd_ptr_d   = rd_ptr_q + PW'(1);
      ram_addr_d = ram_addr_q + 24'd1;
      wr_rem_d   = wr_rem_q - 24'd1;
`ifdef BIOS_LOADER_SUM_EN
      sum_d      = sum_q + {8'h00, ram_wdata_q};
`endif
    end
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    if (pop && !push) cnt_d = cnt_q - CW'(1);

    // When the FIFO drains to empty in the same cycle a byte arrives, the new
    // head has not reached the array yet, so it is forwarded from the flash bus.
    empty_after_pop = (cnt_q == '0) || (pop && cnt_q == CW'(1));
    head_byte       = empty_after_pop ? FLASH_RDATA : mem_q[rd_ptr_d];

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d      = ST_RUN;
          done_d       = 1'b0;
          flash_addr_d = SRC_ADDR;
          ram_addr_d   = DST_ADDR;
          rd_rem_d     = LENGTH;
          wr_rem_d     = LENGTH;
          flash_req_d  = 1'b1;
`ifdef BIOS_LOADER_SUM_EN
          sum_d        = 16'h0000;
`endif
        end
      end
      ST_RUN: begin
        if (!flash_req_d && rd_rem_d != '0 && cnt_d < CW'(FIFO_DEPTH)) begin
          flash_req_d = 1'b1;
        end
        if (push && rd_rem_q == 24'd1) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && wr_rem_q == 24'd1) state_d = ST_FIN;
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_RUN || state_q == ST_DRAIN) && !ram_req_d && cnt_d != '0) begin
      ram_req_d   = 1'b1;
      ram_wdata_d = head_byte;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      flash_req_q  <= 1'b0;
      flash_addr_q <= SRC_ADDR;
      rd_rem_q     <= '0;
      ram_req_q    <= 1'b0;
      ram_addr_q   <= DST_ADDR;
      ram_wdata_q  <= 8'h00;
      wr_rem_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      done_q       <= done_d;
      flash_req_q  <= flash_req_d;
      flash_addr_q <= flash_addr_d;
      rd_rem_q     <= rd_rem_d;
      ram_req_q    <= ram_req_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      wr_rem_q     <= wr_rem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= FLASH_RDATA;
  end

`ifdef BIOS_LOADER_SUM_EN
  always_ff @(posedge CLK) begin
    if (RESET) sum_q <= 16'h0000;
    else       sum_q <= sum_d;
  end
  assign SUM = sum_q;
`else
  assign SUM = 16'h0000;
`endif

  assign BUSY       = (state_q != ST_IDLE);
  assign DONE       = done_q;
  assign FLASH_REQ  = flash_req_q;
  assign FLASH_ADDR = flash_addr_q;
  assign RAM_REQ    = ram_req_q;
  assign RAM_ADDR   = ram_addr_q;
  assign RAM_WDATA  = ram_wdata_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_bios_flash_loader.sv
// Self-checking bench for bios_flash_loader: reactive flash/SD-RAM responders feed a
// scoreboard queue of expected {ram_addr, byte} writes.
module tb_bios_flash_loader;

  localparam logic [23:0] SRC = 24'h10_0000;
  localparam logic [23:0] DST = 24'h70_0000;
  localparam int          LEN = 8;
  localparam int          DEPTH = 4;

  logic        CLK, RESET, START;
  logic        BUSY, DONE, FLASH_REQ, FLASH_ACK, RAM_REQ, RAM_ACK;
  logic [23:0] FLASH_ADDR, RAM_ADDR;
  logic [7:0]  FLASH_RDATA, RAM_WDATA;
  logic [15:0] SUM;
  logic [1:0]  dbg_state;

  bios_flash_loader #(
    .SRC_ADDR(SRC), .DST_ADDR(DST), .LENGTH(24'(LEN)), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .BUSY(BUSY), .DONE(DONE),
    .FLASH_REQ(FLASH_REQ), .FLASH_ADDR(FLASH_ADDR), .FLASH_ACK(FLASH_ACK),
    .FLASH_RDATA(FLASH_RDATA), .RAM_REQ(RAM_REQ), .RAM_ADDR(RAM_ADDR),
    .RAM_WDATA(RAM_WDATA), .RAM_ACK(RAM_ACK), .SUM(SUM), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard and responder state
  logic [31:0] exp_q[$];
  logic [23:0] exp_fl_addr, exp_push_addr;
  logic [15:0] exp_sum;
  logic [7:0]  seed, sim_byte;
  bit          resp_en, ff_mode, sim_pend;
  int          fl_delay, rm_delay, fl_wait, rm_wait;
  int          reads, writes, stall_seen;

  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    return ff_mode ? 8'hFF : (a[7:0] ^ seed);
  endfunction

  initial begin
    int          cnt_before;
    logic [31:0] e;
    FLASH_ACK = 1'b0;
    RAM_ACK = 1'b0;
    FLASH_RDATA = 8'h00;
    fl_wait = 0;
    rm_wait = 0;
    sim_pend = 1'b0;
    forever begin
      @(negedge CLK);
      if (sim_pend) begin
        check("sim_cnt", 32'(dut.cnt_q), 32'd1);
        check("sim_wdata", {23'd0, RAM_REQ, RAM_WDATA}, {23'd0, 1'b1, sim_byte});
        sim_pend = 1'b0;
      end
      FLASH_ACK = 1'b0;
      RAM_ACK = 1'b0;
      cnt_before = reads - writes;
      if (resp_en) begin
        if (BUSY && !FLASH_REQ && cnt_before == DEPTH && reads < LEN) stall_seen++;
        if (FLASH_REQ) begin
          if (fl_wait >= fl_delay) begin
            FLASH_ACK = 1'b1;
            FLASH_RDATA = flash_byte(FLASH_ADDR);
            check("fl_addr", 32'(FLASH_ADDR), 32'(exp_fl_addr));
            check("run_ahead", 32'(cnt_before + 1 <= DEPTH), 32'd1);
            exp_q.push_back({exp_push_addr, FLASH_RDATA});
            exp_fl_addr++;
            exp_push_addr++;
            reads++;
            fl_wait = 0;
          end else fl_wait++;
        end else fl_wait = 0;
        if (RAM_REQ) begin
          if (rm_wait >= rm_delay) begin
            RAM_ACK = 1'b1;
            if (exp_q.size() == 0) check("ram_unexpected", 32'd1, 32'd0);
            else begin
              e = exp_q.pop_front();
              check("ram_wr", {RAM_ADDR, RAM_WDATA}, e);
            end
            exp_sum = exp_sum + {8'h00, RAM_WDATA};
            writes++;
            if (FLASH_ACK && cnt_before == 1) begin
              sim_pend = 1'b1;
              sim_byte = FLASH_RDATA;
            end
            rm_wait = 0;
          end else rm_wait++;
        end else rm_wait = 0;
      end
    end
  end

  // driver tasks
  task automatic clear_sb();
    exp_q.delete();
    exp_fl_addr = SRC;
    exp_push_addr = DST;
    exp_sum = 16'h0000;
    reads = 0;
    writes = 0;
    stall_seen = 0;
  endtask

  task automatic pulse_start(input bit expect_fresh);
    @(negedge CLK);
    #1 START = 1'b1;
    @(negedge CLK);
    if (expect_fresh) begin
      check("start_flash_req", 32'(FLASH_REQ), 32'd1);
      check("start_busy", 32'(BUSY), 32'd1);
      check("start_done_clr", 32'(DONE), 32'd0);
    end
    #1 START = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int busy_cyc);
    int k;
    busy_cyc = 1;
    k = 0;
    while (!DONE && k < budget) begin
      @(negedge CLK);
      if (BUSY) busy_cyc++;
      k++;
    end
    check("done_timeout", 32'(DONE), 32'd1);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k;
    k = 0;
    while (writes < n && k < budget) begin
      @(negedge CLK);
      #1;
      k++;
    end
    check("writes_timeout", 32'(writes >= n), 32'd1);
  endtask

  task automatic end_checks(input string tag);
    check({tag, "_busy"}, 32'(BUSY), 32'd0);
    check({tag, "_count"}, 32'(writes), 32'(LEN));
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
`ifdef BIOS_LOADER_SUM_EN
    check({tag, "_sum"}, 32'(SUM), 32'(exp_sum));
`else
    check({tag, "_sum"}, 32'(SUM), 32'd0);
`endif
  endtask

  initial begin
    int cyc;
    RESET = 1'b1;
    START = 1'b0;
    resp_en = 1'b0;
    ff_mode = 1'b0;
    seed = 8'h00;
    fl_delay = 0;
    rm_delay = 0;
    clear_sb();
    repeat (3) @(negedge CLK);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    check("rst_freq", 32'(FLASH_REQ), 32'd0);
    check("rst_rreq", 32'(RAM_REQ), 32'd0);
    check("rst_faddr", 32'(FLASH_ADDR), 32'(SRC));
    check("rst_raddr", 32'(RAM_ADDR), 32'(DST));
    check("rst_wdata", 32'(RAM_WDATA), 32'd0);
    check("rst_sum", 32'(SUM), 32'd0);
    #1 RESET = 1'b0;
    resp_en = 1'b1;

    // single-cycle ACKs on both sides
    seed = 8'($urandom_range(1, 255));
    clear_sb();
    pulse_start(1'b1);
    @(negedge CLK);
    check("ack_to_ram_req", {23'd0, RAM_REQ, RAM_WDATA}, {23'd0, 1'b1, flash_byte(SRC)});
    wait_done(100, cyc);
    cyc = cyc + 1;
    check("busy_len", 32'(cyc <= 2 * LEN + 4), 32'd1);
    end_checks("fast");

    // slow SD-RAM: FIFO fills, reads stall; START while busy is ignored
    seed = 8'($urandom_range(1, 255));
    fl_delay = 0;
    rm_delay = 10;
    clear_sb();
    pulse_start(1'b1);
    wait_writes(2, 300);
    check("mid_busy", 32'(BUSY), 32'd1);
    pulse_start(1'b0);
    check("mid_done", 32'(DONE), 32'd0);
    wait_done(500, cyc);
    check("fl_stall", 32'(stall_seen > 0), 32'd1);
    end_checks("slow");

    // START after DONE clears DONE and recopies, random latencies
    check("done_sticky", 32'(DONE), 32'd1);
    seed = 8'($urandom_range(1, 255));
    fl_delay = $urandom_range(0, 3);
    rm_delay = $urandom_range(0, 3);
    clear_sb();
    pulse_start(1'b1);
    wait_done(300, cyc);
    end_checks("recopy");

    // reset after 3 bytes aborts, then restart from the base addresses
    fl_delay = 1;
    rm_delay = 2;
    clear_sb();
    pulse_start(1'b1);
    wait_writes(3, 300);
    RESET = 1'b1;
    resp_en = 1'b0;
    @(negedge CLK);
    check("abort_freq", 32'(FLASH_REQ), 32'd0);
    check("abort_rreq", 32'(RAM_REQ), 32'd0);
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_done", 32'(DONE), 32'd0);
    #1 RESET = 1'b0;
    clear_sb();
    resp_en = 1'b1;
    fl_delay = 0;
    rm_delay = 0;
    pulse_start(1'b1);
    wait_done(100, cyc);
    end_checks("restart");

    // all-0xFF image checksum
    ff_mode = 1'b1;
    fl_delay = 1;
    rm_delay = 0;
    clear_sb();
    pulse_start(1'b1);
    wait_done(200, cyc);
    end_checks("ff");
`ifdef BIOS_LOADER_SUM_EN
    check("ff_sum_const", 32'(SUM), 32'h07F8);
`else
    check("ff_sum_const", 32'(SUM), 32'h0000);
`endif

    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
